// File: rtl/vector_loader.sv
// vector_loader: byte-serial element stream -> two packed N_ELEM-element vectors.
// A frame is 2*N_ELEM accepted beats; the first N_ELEM fill vector1, the rest
// fill vector2. The finished frame is held on vector1/vector2 with out_valid
// until the consumer takes it with out_ready.
// Optional build macro: VLOAD_PINGPONG_EN -- keep assembling the next frame
// while the current one is held; only the final beat waits for a free slot.

// One assembly element register: loads on we_i, clears on clr_i (clr wins).
module vload_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // element storage with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset)     q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (we_i)  q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

module vector_loader #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEM_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_ELEM*ELEM_W-1:0] vector1,
  output logic [N_ELEM*ELEM_W-1:0] vector2,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int BEATS = 2 * N_ELEM;
  localparam int IDX_W = $clog2(BEATS);
  localparam int VW    = N_ELEM * ELEM_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic [ELEM_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t beat;
  assign beat = '{data: in_data, last: in_last};

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VW-1:0]    vec1_q, vec1_d, vec2_q, vec2_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Assembly storage for beats 0..BEATS-2; the final beat is taken straight
  // from the input when the frame completes, so it never needs a register.
  logic [BEATS-2:0][ELEM_W-1:0] slot_q;
  logic [BEATS-1:0][ELEM_W-1:0] asm_full;

  logic acc, at_last, bad, done, xfer;

  assign out_valid = (state_q == HOLD);
  assign at_last   = (idx_q == LAST_IDX);

  // in_ready depends only on registered state and reset, never on in_valid/out_ready
`ifdef VLOAD_PINGPONG_EN
  assign in_ready = reset & ~(at_last & out_valid);
`else
  assign in_ready = reset & (state_q == FILL);
`endif

  assign acc  = in_valid & in_ready;
  assign bad  = acc & (beat.last ^ at_last);
  assign done = acc & beat.last & at_last;
  assign xfer = out_valid & out_ready;

  for (genvar k = 0; k < BEATS - 1; k++) begin : g_slot
    vload_slot #(.W(ELEM_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we_i  (acc & (idx_q == IDX_W'(k))),
      .clr_i (bad | done),
      .d_i   (beat.data),
      .q_o   (slot_q[k])
    );
  end

  assign asm_full = {beat.data, slot_q};

  // next-state: beat index, hold/fill state, output copy, error pulse, counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec1_d  = vec1_q;
    vec2_d  = vec2_q;
    err_d   = bad;
    cnt_d   = cnt_q;
    if (bad || done)  idx_d = '0;
    else if (acc)     idx_d = idx_q + IDX_W'(1);
    // a completion can only happen with the output slot already empty, so
    // transfer and completion never collide in the same cycle
    if (xfer) begin
      state_d = FILL;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (done) begin
      state_d = HOLD;
      vec1_d  = asm_full[N_ELEM-1:0];
      vec2_d  = asm_full[BEATS-1:N_ELEM];
    end
  end

  // control and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      vec1_q  <= '0;
      vec2_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec1_q  <= vec1_d;
      vec2_q  <= vec2_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vector1   = vec1_q;
  assign vector2   = vec2_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_vector_loader.sv
// Bench for vector_loader: directed frames plus randomized traffic, checked
// every cycle against a transaction-level model built from a beat queue.
module tb_vector_loader;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 10;
  localparam int CNT_W  = 16;
  localparam int BEATS  = 2 * N_ELEM;
  localparam int VW     = N_ELEM * ELEM_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_last;
  logic [ELEM_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [VW-1:0]     vector1, vector2;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  vector_loader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .vector1(vector1), .vector2(vector2),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [ELEM_W-1:0] mq[$];
  bit                m_hold;
  logic [VW-1:0]     m_v1, m_v2;
  bit                m_err;
  int                m_cnt;
  bit                m_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic bit exp_ready(input bit rst);
`ifdef VLOAD_PINGPONG_EN
    return rst && !(m_hold && mq.size() == BEATS - 1);
`else
    return rst && !m_hold;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hold = 0; m_v1 = '0; m_v2 = '0; m_err = 0; m_cnt = 0;
  endtask

  // one clock: drive, check at negedge, advance model at posedge
  task automatic cycle(input bit v, input logic [ELEM_W-1:0] d, input bit l,
                       input bit ordy, input bit rst);
    bit rdy, xf, e;
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; reset = rst;
    @(negedge clk);
    rdy = exp_ready(rst);
    chk("in_ready",  in_ready,  rdy);
    chk("out_valid", out_valid, m_hold);
    chk("vector1",   vector1,   m_v1);
    chk("vector2",   vector2,   m_v2);
    chk("frame_err", frame_err, m_err);
    chk("frame_cnt", frame_cnt, 128'(m_cnt));
    m_acc = v && rdy;
    xf    = m_hold && ordy;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      e = 0;
      if (xf) begin
        m_hold = 0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
      if (m_acc) begin
        if (l != (mq.size() == BEATS - 1)) begin
          e = 1;
          mq.delete();
        end else begin
          mq.push_back(d);
          if (mq.size() == BEATS) begin
            for (int j = 0; j < N_ELEM; j++) begin
              m_v1[j*ELEM_W +: ELEM_W] = mq[j];
              m_v2[j*ELEM_W +: ELEM_W] = mq[N_ELEM + j];
            end
            m_hold = 1;
            mq.delete();
          end
        end
      end
      m_err = e;
    end
    #1;
  endtask

  // n beats of value base+i; in_last on beat index last_at (-1: never)
  task automatic send_frame(input int n, input int last_at, input int base, input bit ordy);
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      do begin
        cycle(1, ELEM_W'(base + i), (i == last_at), ordy, 1);
        tries++;
      end while (!m_acc && tries < 100);
      chk("beat_accepted", m_acc, 1);
    end
  endtask

  initial begin
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    chk("reset_in_ready", in_ready, 0);

    // basic frame, consumer ready
    send_frame(BEATS, BEATS - 1, 1, 1);
    chk("t1_latency", out_valid, 1);
    chk("t1_v1_e0", vector1[7:0], 1);
    chk("t1_v1_e9", vector1[79:72], 10);
    chk("t1_v2_e0", vector2[7:0], 11);
    chk("t1_v2_e9", vector2[79:72], 20);
    cycle(0, 0, 0, 1, 1);
    chk("t1_cnt", frame_cnt, 1);

    // consumer stalls for 5 cycles
    send_frame(BEATS, BEATS - 1, 1, 0);
    repeat (5) cycle(0, 0, 0, 0, 1);
    chk("t2_held", out_valid, 1);
    chk("t2_v2_e9", vector2[79:72], 20);
`ifndef VLOAD_PINGPONG_EN
    chk("t2_in_ready", in_ready, 0);
`endif
    cycle(0, 0, 0, 1, 1);
    chk("t2_released", out_valid, 0);
    chk("t2_in_ready_after", in_ready, 1);
    chk("t2_cnt", frame_cnt, 2);

    // early in_last on beat 7
    send_frame(7, 6, 50, 1);
    chk("t3_err", frame_err, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t3_err_pulse", frame_err, 0);
    send_frame(BEATS, BEATS - 1, 100, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t3_cnt", frame_cnt, 3);
    chk("t3_v1_e0", vector1[7:0], 100);
    chk("t3_v2_e9", vector2[79:72], 119);

    // missing in_last on beat 20
    send_frame(BEATS, -1, 150, 1);
    chk("t4_err", frame_err, 1);
    chk("t4_no_valid", out_valid, 0);
    chk("t4_retained", vector1[7:0], 100);

    // reset after beat 12
    send_frame(12, -1, 30, 1);
    cycle(0, 0, 0, 1, 0);
    chk("t5_vec1_zero", vector1, 0);
    chk("t5_cnt_zero", frame_cnt, 0);
    send_frame(BEATS, BEATS - 1, 60, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t5_v1_e0", vector1[7:0], 60);
    chk("t5_v2_e9", vector2[79:72], 79);
    chk("t5_cnt", frame_cnt, 1);

`ifdef VLOAD_PINGPONG_EN
    // back-to-back frames with the consumer always ready
    cycle(0, 0, 0, 1, 0);
    begin
      int sent = 0;
      for (int c = 0; c < 3 * BEATS + 1; c++) begin
        bit v = (sent < 3 * BEATS);
        cycle(v, ELEM_W'($urandom), v && (mq.size() == BEATS - 1), 1, 1);
        if (m_acc) sent++;
      end
      chk("pp_sent", sent, 3 * BEATS);
      chk("pp_cnt", frame_cnt, 3);
    end
`endif

    // randomized traffic with occasional framing errors and resets
    for (int c = 0; c < 1500; c++) begin
      bit v    = ($urandom_range(0, 3) != 0);
      bit ordy = ($urandom_range(0, 2) != 0);
      bit rst  = ($urandom_range(0, 199) != 0);
      bit l    = (mq.size() == BEATS - 1);
      if ($urandom_range(0, 49) == 0) l = ~l;
      cycle(v, ELEM_W'($urandom), l, ordy, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
